uart_byte_rx: RTL and testbench
===============================

Name: uart_byte_rx

Overview:
Asynchronous serial (8N1, LSB first) byte receiver. Converts the raw rx pin into parallel bytes with a one-cycle valid strobe. Sits directly upstream of the byte-stream pattern detectors ("Hello" detector, command parsers), which qualify data_out with valid_out. Oversamples with a baud counter and samples every bit at its mid-point.

Parameters:
CLKS_PER_BIT, 434, clk_in cycles per bit (50 MHz / 115200); legal range >= 4; counter width = $clog2(CLKS_PER_BIT).
SYNC_STAGES, 2, synchronizer flops on rx_in; legal range >= 2.

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset: asynchronous, active-low
rx_in  input  1  raw serial line; idle high; asynchronous to clk_in
data_out  output  8  last good byte; holds until next good byte
valid_out  output  1  one-cycle pulse when data_out is updated
frame_err_out  output  1  one-cycle pulse when the stop bit samples 0
busy_out  output  1  high while the FSM is not IDLE

Behaviour:
- Reset (async, active-low): data_out=8'h00, valid_out=0, frame_err_out=0, busy_out=0, FSM=IDLE, synchronizer flops=1, bit index=0, baud counter=0.
- rx_in passes through SYNC_STAGES flops to give rx_s. A start is a falling edge on rx_s (previous 1, current 0). rx held low at reset release is not a start.
- FSM states, one-hot:
  - IDLE: on falling edge go to START and clear the counter.
  - START: at count == CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA and clear the counter and bit index. If 1, treat it as a glitch: go to IDLE with no output pulses.
  - DATA: at count == CLKS_PER_BIT-1, shift rx_s into shift_reg[7] (right shift, LSB first) and increment the bit index. After the 8th sample go to STOP.
  - STOP: at count == CLKS_PER_BIT-1, sample rx_s. If 1, register data_out<=shift_reg and valid_out<=1. If 0, register frame_err_out<=1 and leave data_out unchanged. Both cases go to IDLE.
- Pulses are registered and last exactly one cycle. valid_out and frame_err_out are mutually exclusive.
- Latency from the first rx_s==0 cycle to the valid_out cycle is CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk_in cycles, plus SYNC_STAGES of input latency.
- Returning to IDLE at mid-stop allows back-to-back frames with a single stop bit.
- Break (line held low through stop): one frame_err_out pulse. No new frame starts until rx_s has gone high and then falls again.
- Reset asserted mid-frame: immediate return to reset values; the partial byte is discarded.
- Illegal or unused state encoding goes to IDLE.
- busy_out = (state != IDLE), registered with the state.

Optional Feature:
Macro UART_RX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and samples an even-parity bit at full-bit timing. An extra output, parity_err_out (1 bit, reset 0), pulses for one cycle in place of valid_out when the XOR of the 8 data bits and the parity bit is 1; data_out is not updated. Frame errors take priority over parity errors. Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity_err_out port; behaviour is exactly 8N1.

Decomposition:
- Shared include/package uart_defs: state encodings (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP), the DATA_BITS=8 constant, and the default CLKS_PER_BIT. The same file is reused by the future uart_byte_tx.
- One sub-module: sync_bit, a parameterised SYNC_STAGES flop chain with a reset value of 1. It is reusable for other async inputs.
- The FSM, baud counter and shift register stay in uart_byte_rx.

Test Plan:
- CLKS_PER_BIT=8. Send 0x48 'H' -> data_out=8'h48, a single valid_out pulse at edge+4+72+1+2 cycles, busy_out low afterwards.
- Send "Hello" back-to-back with one stop bit -> five valid_out pulses carrying 0x48, 0x65, 0x6C, 0x6C, 0x6F, and no frame_err_out.
- A 2-cycle low glitch on rx_in, then idle -> no valid_out or frame_err_out; busy_out high for at most 4 cycles plus sync latency.
- Send 0x55 with the stop bit forced to 0 after a prior good 0x3C -> one frame_err_out pulse; data_out stays 8'h3C.
- Assert rst_n_in after 3 data bits of 0xFF -> all outputs 0 asynchronously. A following 0xA5 frame yields data_out=8'hA5 and one valid_out pulse.
- UART_RX_PARITY_EN defined: 0x48 with parity bit 0 -> valid_out. 0x48 with parity bit 1 -> parity_err_out pulse and data_out unchanged.

Source files
------------

// File: rtl/uart_defs_pkg.sv
// ----------------------------------------------------------------------------
// uart_defs : definitions shared by the UART byte receiver and transmitter.
//
// Contents
//   DATA_BITS             data bits per frame (8N1 framing)
//   DEFAULT_CLKS_PER_BIT  clk cycles per bit (50 MHz / 115200 baud)
//   uart_state_t          one-hot frame FSM encoding
//                         (ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP)
//   parity_mismatch()     even-parity check of a data byte plus its parity bit
// ----------------------------------------------------------------------------
package uart_defs;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  // One-hot so that any encoding with zero or several bits set is illegal and
  // falls into the FSM default branch.
  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_START  = 5'b00010,
    ST_DATA   = 5'b00100,
    ST_PARITY = 5'b01000,
    ST_STOP   = 5'b10000
  } uart_state_t;

  // Even parity: the data bits and the parity bit together hold an even
  // number of ones, so a non-zero XOR reduction means the parity is wrong.
  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/sync_bit.sv
// ----------------------------------------------------------------------------
// sync_bit : multi-flop synchronizer for a single asynchronous input bit.
//
// Parameters
//   SYNC_STAGES  number of flops in the chain (>= 2)
//
// Ports
//   clk_in    input   destination clock
//   rst_n_in  input   asynchronous, active-low reset; every flop resets to 1
//                     (the idle level of a UART line)
//   d         input   asynchronous input bit
//   q         output  synchronized bit, SYNC_STAGES cycles behind d
// ----------------------------------------------------------------------------
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      chain <= '1;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_byte_rx.sv
// ----------------------------------------------------------------------------
// uart_byte_rx : asynchronous serial byte receiver (8N1, LSB first).
//
// The rx line is synchronized, a falling edge starts a frame, the start bit is
// re-checked at its mid-point and every following bit is sampled one full bit
// period later, i.e. also at its mid-point. The FSM returns to IDLE at the
// middle of the stop bit, so frames may follow each other with a single stop
// bit.
//
// Build option
//   UART_RX_PARITY_EN  when defined, an even-parity bit is expected between
//                      the data bits and the stop bit, and parity_err_out is
//                      added to the port list.
//
// Parameters
//   CLKS_PER_BIT  clk_in cycles per serial bit (>= 4)
//   SYNC_STAGES   synchronizer depth on rx_in (>= 2)
//
// Ports
//   clk_in          input   system clock
//   rst_n_in        input   asynchronous, active-low reset
//   rx_in           input   raw serial line, idle high, asynchronous
//   data_out        output  last good byte, held until the next good byte
//   valid_out       output  one-cycle pulse when data_out is updated
//   frame_err_out   output  one-cycle pulse when the stop bit samples 0
//   parity_err_out  output  (UART_RX_PARITY_EN only) one-cycle pulse instead
//                           of valid_out when the parity is wrong
//   busy_out        output  high while a frame is being received
// ----------------------------------------------------------------------------
module uart_byte_rx
  import uart_defs::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err_out,
`endif
  output logic                 busy_out
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  uart_state_t          state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 rx_s;
  logic                 rx_prev;
  logic [SYNC_STAGES:0] primed;
  logic                 start_edge;
  logic                 data_tick;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit;
  logic                 parity_tick;
`endif

  sync_bit #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (rx_in),
    .q        (rx_s)
  );

  // The synchronizer comes out of reset holding 1s, so for the first
  // SYNC_STAGES+1 cycles rx_prev may still be showing that reset value rather
  // than a real line sample. Edge detection is held off until then, which
  // keeps a line that is already low at reset release from looking like a
  // start bit.
  assign start_edge = primed[SYNC_STAGES] & rx_prev & ~rx_s;

  assign data_tick = (state == ST_DATA) && (cnt == CNT_FULL);

  // Data-path capture: right shift so the first (LSB) bit ends in bit 0.
  always_ff @(posedge clk_in) begin
    if (data_tick) begin
      shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  assign parity_tick = (state == ST_PARITY) && (cnt == CNT_FULL);

  always_ff @(posedge clk_in) begin
    if (parity_tick) begin
      parity_bit <= rx_s;
    end
  end
`endif

  // Frame FSM, baud counter and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      data_out       <= '0;
      valid_out      <= 1'b0;
      frame_err_out  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_out <= 1'b0;
`endif
      busy_out       <= 1'b0;
      rx_prev        <= 1'b1;
      primed         <= '0;
    end else begin
      valid_out      <= 1'b0;
      frame_err_out  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_out <= 1'b0;
`endif
      rx_prev        <= rx_s;
      primed         <= {primed[SYNC_STAGES-1:0], 1'b1};

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (start_edge) begin
            state    <= ST_START;
            busy_out <= 1'b1;
          end
        end

        // Mid-point of the start bit: a line that is high again was a glitch.
        ST_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              state    <= ST_IDLE;
              busy_out <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        ST_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            bit_idx <= bit_idx + IW'(1);
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt == CNT_FULL) begin
            cnt   <= '0;
            state <= ST_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif

        // Mid-point of the stop bit: deliver the byte or flag the error and
        // go straight back to IDLE so the next start edge is not missed.
        ST_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt      <= '0;
            state    <= ST_IDLE;
            busy_out <= 1'b0;
            if (!rx_s) begin
              frame_err_out <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (parity_mismatch(shift_reg, parity_bit)) begin
              parity_err_out <= 1'b1;
`endif
            end else begin
              data_out  <= shift_reg;
              valid_out <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
module tb_uart_byte_rx;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit USE_PAR = 1'b1;
`else
  localparam bit USE_PAR = 1'b0;
`endif
  // From the first rx_in low cycle: 2 sync cycles + half bit + 9 bits + 1
  // (+ one more bit when a parity bit is in the frame).
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + (USE_PAR ? CPB : 0);

  logic       clk_in = 1'b0;
  logic       rst_n_in = 1'b1;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err_out;
  logic       parity_err_out;
  logic       busy_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_cycles = 0;
  logic [7:0] model_data = 8'h00;

  logic [2:0] ev_kind[$];
  int         ev_cyc[$];
  logic [7:0] ev_data[$];

  uart_byte_rx #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (2)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rx_in         (rx_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .frame_err_out (frame_err_out),
`ifdef UART_RX_PARITY_EN
    .parity_err_out(parity_err_out),
`endif
    .busy_out      (busy_out)
  );

`ifndef UART_RX_PARITY_EN
  assign parity_err_out = 1'b0;
`endif

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Event recorder: kind = {parity_err, frame_err, valid}.
  always @(negedge clk_in) begin
    if (busy_out) busy_cycles <= busy_cycles + 1;
    if (valid_out || frame_err_out || parity_err_out) begin
      ev_kind.push_back({parity_err_out, frame_err_out, valid_out});
      ev_cyc.push_back(cyc);
      ev_data.push_back(data_out);
    end
  end

  // Reference rule for what one frame should produce.
  function automatic logic [2:0] exp_kind(input logic [7:0] b, input logic stop,
                                          input logic par);
    if (!stop) return 3'b010;
    if (USE_PAR && ((^b) ^ par)) return 3'b100;
    return 3'b001;
  endfunction

  task automatic drive_bits(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par,
                            output int start);
    start = cyc;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(b[i], CPB);
    if (USE_PAR) drive_bits(par, CPB);
    drive_bits(stop, CPB);
  endtask

  task automatic test_reset();
    #1 rst_n_in = 1'b0;
    #1;
    n_checks++;
    if ({data_out, valid_out, frame_err_out, parity_err_out, busy_out} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_values: got data=%h v=%b fe=%b pe=%b busy=%b, expected all 0",
               data_out, valid_out, frame_err_out, parity_err_out, busy_out);
    end
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    model_data = 8'h00;
    drive_bits(1'b1, 10);
    n_checks++;
    if (busy_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy_out);
    end
  endtask

  task automatic test_rx_low_at_reset();
    int e0, b0;
    rx_in = 1'b0;
    rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    e0 = ev_kind.size(); b0 = busy_cycles;
    drive_bits(1'b0, 30);
    drive_bits(1'b1, 20);
    n_checks++;
    if (busy_cycles - b0 != 0) begin
      n_fail++; $display("FAIL low_at_reset_busy: got %0d busy cycles expected 0", busy_cycles - b0);
    end
    n_checks++;
    if (ev_kind.size() - e0 != 0) begin
      n_fail++; $display("FAIL low_at_reset_events: got %0d expected 0", ev_kind.size() - e0);
    end
  endtask

  task automatic test_single();
    int e0, st;
    e0 = ev_kind.size();
    send_frame(8'h48, 1'b1, ^8'h48, st);
    drive_bits(1'b1, 20);
    n_checks++;
    if (ev_kind.size() - e0 != 1) begin
      n_fail++; $display("FAIL single_count: got %0d expected 1", ev_kind.size() - e0);
    end else begin
      n_checks++;
      if (ev_kind[e0] !== 3'b001 || ev_data[e0] !== 8'h48) begin
        n_fail++; $display("FAIL single_data: got kind=%b data=%h expected 001/48", ev_kind[e0], ev_data[e0]);
      end
      n_checks++;
      if (ev_cyc[e0] != st + LAT) begin
        n_fail++; $display("FAIL single_latency: got %0d expected %0d", ev_cyc[e0] - st, LAT);
      end
    end
    model_data = 8'h48;
    n_checks++;
    if (busy_out !== 1'b0 || data_out !== 8'h48) begin
      n_fail++; $display("FAIL single_after: got busy=%b data=%h expected 0/48", busy_out, data_out);
    end
  endtask

  task automatic test_hello();
    logic [7:0] msg[5] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    int st[5];
    int e0;
    e0 = ev_kind.size();
    for (int i = 0; i < 5; i++) send_frame(msg[i], 1'b1, ^msg[i], st[i]);
    drive_bits(1'b1, 20);
    n_checks++;
    if (ev_kind.size() - e0 != 5) begin
      n_fail++; $display("FAIL hello_count: got %0d expected 5", ev_kind.size() - e0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (ev_kind[e0+i] !== 3'b001 || ev_data[e0+i] !== msg[i] || ev_cyc[e0+i] != st[i] + LAT) begin
          n_fail++;
          $display("FAIL hello_byte%0d: got kind=%b data=%h lat=%0d expected 001/%h/%0d",
                   i, ev_kind[e0+i], ev_data[e0+i], ev_cyc[e0+i] - st[i], msg[i], LAT);
        end
      end
    end
    model_data = 8'h6F;
  endtask

  task automatic test_glitch();
    int e0, b0;
    e0 = ev_kind.size(); b0 = busy_cycles;
    drive_bits(1'b0, 2);
    drive_bits(1'b1, 30);
    n_checks++;
    if (ev_kind.size() - e0 != 0) begin
      n_fail++; $display("FAIL glitch_events: got %0d expected 0", ev_kind.size() - e0);
    end
    n_checks++;
    if (busy_cycles - b0 < 1 || busy_cycles - b0 > CPB / 2) begin
      n_fail++; $display("FAIL glitch_busy: got %0d busy cycles expected 1..%0d", busy_cycles - b0, CPB / 2);
    end
  endtask

  task automatic test_frame_err();
    int e0, s0, s1;
    e0 = ev_kind.size();
    send_frame(8'h3C, 1'b1, ^8'h3C, s0);
    drive_bits(1'b1, 5);
    send_frame(8'h55, 1'b0, ^8'h55, s1);
    drive_bits(1'b1, 20);
    n_checks++;
    if (ev_kind.size() - e0 != 2) begin
      n_fail++; $display("FAIL ferr_count: got %0d expected 2", ev_kind.size() - e0);
    end else begin
      n_checks++;
      if (ev_kind[e0+1] !== 3'b010 || ev_cyc[e0+1] != s1 + LAT) begin
        n_fail++; $display("FAIL ferr_pulse: got kind=%b lat=%0d expected 010/%0d",
                           ev_kind[e0+1], ev_cyc[e0+1] - s1, LAT);
      end
    end
    model_data = 8'h3C;
    n_checks++;
    if (data_out !== model_data) begin
      n_fail++; $display("FAIL ferr_data_hold: got %h expected %h", data_out, model_data);
    end
  endtask

  task automatic test_break();
    int e0, st;
    e0 = ev_kind.size();
    send_frame(8'h00, 1'b0, 1'b0, st);
    drive_bits(1'b0, 40);
    drive_bits(1'b1, 30);
    n_checks++;
    if (ev_kind.size() - e0 != 1) begin
      n_fail++; $display("FAIL break_count: got %0d expected 1", ev_kind.size() - e0);
    end else begin
      n_checks++;
      if (ev_kind[e0] !== 3'b010) begin
        n_fail++; $display("FAIL break_kind: got %b expected 010", ev_kind[e0]);
      end
    end
    n_checks++;
    if (busy_out !== 1'b0 || data_out !== model_data) begin
      n_fail++; $display("FAIL break_after: got busy=%b data=%h expected 0/%h", busy_out, data_out, model_data);
    end
  endtask

  task automatic test_reset_mid_frame();
    int e0, st;
    drive_bits(1'b0, CPB);
    drive_bits(1'b1, 3 * CPB);
    #2 rst_n_in = 1'b0;
    #1;
    n_checks++;
    if ({data_out, valid_out, frame_err_out, parity_err_out, busy_out} !== 12'h000) begin
      n_fail++;
      $display("FAIL midreset_values: got data=%h v=%b fe=%b pe=%b busy=%b, expected all 0",
               data_out, valid_out, frame_err_out, parity_err_out, busy_out);
    end
    repeat (3) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    model_data = 8'h00;
    e0 = ev_kind.size();
    drive_bits(1'b1, 20);
    send_frame(8'hA5, 1'b1, ^8'hA5, st);
    drive_bits(1'b1, 20);
    n_checks++;
    if (ev_kind.size() - e0 != 1) begin
      n_fail++; $display("FAIL midreset_count: got %0d expected 1", ev_kind.size() - e0);
    end else begin
      n_checks++;
      if (ev_kind[e0] !== 3'b001 || ev_data[e0] !== 8'hA5 || ev_cyc[e0] != st + LAT) begin
        n_fail++; $display("FAIL midreset_frame: got kind=%b data=%h lat=%0d expected 001/A5/%0d",
                           ev_kind[e0], ev_data[e0], ev_cyc[e0] - st, LAT);
      end
    end
    model_data = 8'hA5;
  endtask

  task automatic test_random();
    localparam int N = 10;
    logic [7:0] b[N];
    logic       sb[N];
    logic [2:0] k[N];
    logic [7:0] d[N];
    int         st[N];
    int         e0, gap;
    e0 = ev_kind.size();
    for (int i = 0; i < N; i++) begin
      b[i]  = 8'($urandom);
      sb[i] = (i == 0) || ($urandom_range(3) != 0);
      k[i]  = exp_kind(b[i], sb[i], ^b[i]);
      if (k[i] == 3'b001) model_data = b[i];
      d[i]  = model_data;
      send_frame(b[i], sb[i], ^b[i], st[i]);
      gap = int'($urandom_range(15));
      if (!sb[i] && gap < 2) gap = 2;
      drive_bits(1'b1, gap);
    end
    drive_bits(1'b1, 20);
    n_checks++;
    if (ev_kind.size() - e0 != N) begin
      n_fail++; $display("FAIL random_count: got %0d expected %0d", ev_kind.size() - e0, N);
    end else begin
      for (int i = 0; i < N; i++) begin
        n_checks++;
        if (ev_kind[e0+i] !== k[i] || ev_data[e0+i] !== d[i] || ev_cyc[e0+i] != st[i] + LAT) begin
          n_fail++;
          $display("FAIL random_frame%0d: got kind=%b data=%h lat=%0d expected %b/%h/%0d",
                   i, ev_kind[e0+i], ev_data[e0+i], ev_cyc[e0+i] - st[i], k[i], d[i], LAT);
        end
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int e0, s0, s1;
    e0 = ev_kind.size();
    send_frame(8'h48, 1'b1, 1'b0, s0);
    drive_bits(1'b1, 5);
    send_frame(8'h48 ^ 8'h01, 1'b1, 1'b0, s1);
    drive_bits(1'b1, 20);
    n_checks++;
    if (ev_kind.size() - e0 != 2) begin
      n_fail++; $display("FAIL parity_count: got %0d expected 2", ev_kind.size() - e0);
    end else begin
      n_checks++;
      if (ev_kind[e0] !== 3'b001 || ev_data[e0] !== 8'h48) begin
        n_fail++; $display("FAIL parity_good: got kind=%b data=%h expected 001/48", ev_kind[e0], ev_data[e0]);
      end
      n_checks++;
      if (ev_kind[e0+1] !== 3'b100 || ev_data[e0+1] !== 8'h48 || ev_cyc[e0+1] != s1 + LAT) begin
        n_fail++; $display("FAIL parity_bad: got kind=%b data=%h lat=%0d expected 100/48/%0d",
                           ev_kind[e0+1], ev_data[e0+1], ev_cyc[e0+1] - s1, LAT);
      end
    end
    model_data = 8'h48;
    // Bad stop and bad parity together: the frame error wins.
    e0 = ev_kind.size();
    send_frame(8'h48, 1'b0, 1'b1, s0);
    drive_bits(1'b1, 20);
    n_checks++;
    if (ev_kind.size() - e0 != 1 || ev_kind[e0] !== 3'b010) begin
      n_fail++; $display("FAIL parity_priority: got %0d events expected one 010", ev_kind.size() - e0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rx_low_at_reset();
    test_single();
    test_hello();
    test_glitch();
    test_frame_err();
    test_break();
    test_reset_mid_frame();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
